// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Brief    : Instruction-memory programming controller. Streams an image
//             into one or more cores' instruction memories, optionally reads
//             it back against a running checksum, then releases the cores.
//  Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int DATA_SIZE  = 32,
    parameter int ADRS_WIDTH = 11,
    parameter int NUM_CORES  = 2,
    parameter int VERIFY_EN  = 1,
    parameter int CW         = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                  sys_clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ADRS_WIDTH-1:0] base_adrs,
    input  logic [NUM_CORES-1:0]  core_mask,
    input  logic                  s_valid,
    input  logic [DATA_SIZE-1:0]  s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [NUM_CORES-1:0]  w_enable,
    output logic [ADRS_WIDTH-1:0] w_adrs,
    output logic [DATA_SIZE-1:0]  w_instruction,
    output logic [CW-1:0]         rd_core,
    output logic [ADRS_WIDTH-1:0] rd_adrs,
    input  logic [DATA_SIZE-1:0]  rd_data,
    output logic                  cpu_en,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            err,
    output logic [ADRS_WIDTH:0]   word_count
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_load   = 3'd1;
    localparam logic [2:0] c_st_drain  = 3'd2;
    localparam logic [2:0] c_st_verify = 3'd3;
    localparam logic [2:0] c_st_check  = 3'd4;
    localparam logic [2:0] c_st_run    = 3'd5;
    localparam logic [2:0] c_st_error  = 3'd6;

    localparam logic [1:0] c_err_none  = 2'b00;
    localparam logic [1:0] c_err_sum   = 2'b01;
    localparam logic [1:0] c_err_ovf   = 2'b10;

    // Word count at which the memory is completely filled.
    localparam logic [ADRS_WIDTH:0]   c_full     = {1'b1, {ADRS_WIDTH{1'b0}}};
    localparam logic [ADRS_WIDTH:0]   c_cnt_one  = 1;
    localparam logic [ADRS_WIDTH-1:0] c_adrs_one = 1;

    logic [2:0]            r_state;
    logic [ADRS_WIDTH-1:0] r_base;
    logic [NUM_CORES-1:0]  r_mask;
    logic [ADRS_WIDTH:0]   r_word_count;
    logic [ADRS_WIDTH:0]   r_vcnt;
    logic [DATA_SIZE-1:0]  r_sum_wr;
    logic [DATA_SIZE-1:0]  r_sum_rd;
    logic                  r_s_ready;
    logic [NUM_CORES-1:0]  r_w_enable;
    logic [ADRS_WIDTH-1:0] r_w_adrs;
    logic [DATA_SIZE-1:0]  r_w_instruction;
    logic [CW-1:0]         r_rd_core;
    logic [ADRS_WIDTH-1:0] r_rd_adrs;
    logic                  r_cpu_en;
    logic                  r_busy;
    logic                  r_done;
    logic [1:0]            r_err;

    logic [CW-1:0]         w_low_core;
    logic [ADRS_WIDTH-1:0] w_wr_adrs;
    logic                  w_beat;

    // Verify reads from the lowest-numbered selected core; all selected
    // cores received identical writes, so one is representative.
    always_comb begin
        w_low_core = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (r_mask[i]) w_low_core = CW'(i);
        end
    end

    // Write address wraps naturally through the ADRS_WIDTH-bit adder.
    assign w_wr_adrs = r_base + r_word_count[ADRS_WIDTH-1:0];
    assign w_beat    = s_valid & r_s_ready;

    // Controller state machine with all outputs registered.
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            r_state         <= c_st_idle;
            r_base          <= '0;
            r_mask          <= '0;
            r_word_count    <= '0;
            r_vcnt          <= '0;
            r_sum_wr        <= '0;
            r_sum_rd        <= '0;
            r_s_ready       <= 1'b0;
            r_w_enable      <= '0;
            r_w_adrs        <= '0;
            r_w_instruction <= '0;
            r_rd_core       <= '0;
            r_rd_adrs       <= '0;
            r_cpu_en        <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_err           <= c_err_none;
        end else begin
            r_w_enable <= '0;
            r_done     <= 1'b0;
            case (r_state)
                c_st_idle, c_st_run, c_st_error: begin
                    if (start && (core_mask != '0)) begin
                        r_base       <= base_adrs;
                        r_mask       <= core_mask;
                        r_word_count <= '0;
                        r_sum_wr     <= '0;
                        r_sum_rd     <= '0;
                        r_err        <= c_err_none;
                        r_cpu_en     <= 1'b0;
                        r_s_ready    <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= c_st_load;
                    end
                end
                c_st_load: begin
                    if (w_beat) begin
                        if (r_word_count == c_full) begin
                            // Memory already full: drop the beat and abort.
                            r_err     <= c_err_ovf;
                            r_s_ready <= 1'b0;
                            r_busy    <= 1'b0;
                            r_state   <= c_st_error;
                        end else begin
                            r_w_enable      <= r_mask;
                            r_w_adrs        <= w_wr_adrs;
                            r_w_instruction <= s_data;
                            r_word_count    <= r_word_count + c_cnt_one;
                            r_sum_wr        <= r_sum_wr + s_data;
                            if (s_last) begin
                                r_s_ready <= 1'b0;
                                r_state   <= c_st_drain;
                            end
                        end
                    end
                end
                c_st_drain: begin
                    if (VERIFY_EN != 0) begin
                        r_rd_core <= w_low_core;
                        r_rd_adrs <= r_base;
                        r_vcnt    <= '0;
                        r_state   <= c_st_verify;
                    end else begin
                        r_cpu_en <= 1'b1;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= c_st_run;
                    end
                end
                c_st_verify: begin
                    // Read data lags the address by one cycle, so the first
                    // verify cycle has nothing to accumulate.
                    if (r_vcnt != '0) r_sum_rd <= r_sum_rd + rd_data;
                    if (r_vcnt == r_word_count) begin
                        r_state <= c_st_check;
                    end else begin
                        r_vcnt <= r_vcnt + c_cnt_one;
                        if ((r_vcnt + c_cnt_one) < r_word_count) begin
                            r_rd_adrs <= r_rd_adrs + c_adrs_one;
                        end
                    end
                end
                c_st_check: begin
                    r_busy <= 1'b0;
                    if (r_sum_rd == r_sum_wr) begin
                        r_cpu_en <= 1'b1;
                        r_done   <= 1'b1;
                        r_state  <= c_st_run;
                    end else begin
                        r_err   <= c_err_sum;
                        r_state <= c_st_error;
                    end
                end
                default: begin
                    r_s_ready <= 1'b0;
                    r_busy    <= 1'b0;
                    r_cpu_en  <= 1'b0;
                    r_state   <= c_st_idle;
                end
            endcase
        end
    end

    assign s_ready       = r_s_ready;
    assign w_enable      = r_w_enable;
    assign w_adrs        = r_w_adrs;
    assign w_instruction = r_w_instruction;
    assign rd_core       = r_rd_core;
    assign rd_adrs       = r_rd_adrs;
    assign cpu_en        = r_cpu_en;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign word_count    = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_loader
//  Brief    : Directed self-checking bench for prog_loader with a two-core
//             instruction memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic        sys_clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [10:0] base_adrs;
    logic [1:0]  core_mask;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;
    logic        s_ready;
    logic [1:0]  w_enable;
    logic [10:0] w_adrs;
    logic [31:0] w_instruction;
    logic [0:0]  rd_core;
    logic [10:0] rd_adrs;
    logic [31:0] rd_data;
    logic        cpu_en;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic [11:0] word_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:1][0:2047];
    logic        corrupt = 1'b0;

    logic [1:0]  q_en   [$];
    logic [10:0] q_adrs [$];
    logic [31:0] q_data [$];
    int          done_seen = 0;
    int          wr_count  = 0;

    logic [31:0] d4 [4] = '{32'h0000000d, 32'h0000000b, 32'h00000000, 32'hffffffff};

    prog_loader #(
        .DATA_SIZE (32),
        .ADRS_WIDTH(11),
        .NUM_CORES (2),
        .VERIFY_EN (1)
    ) dut (
        .sys_clk      (sys_clk),
        .resetn       (resetn),
        .start        (start),
        .base_adrs    (base_adrs),
        .core_mask    (core_mask),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .w_enable     (w_enable),
        .w_adrs       (w_adrs),
        .w_instruction(w_instruction),
        .rd_core      (rd_core),
        .rd_adrs      (rd_adrs),
        .rd_data      (rd_data),
        .cpu_en       (cpu_en),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .word_count   (word_count)
    );

    always #5 sys_clk = ~sys_clk;

    // Instruction memory: synchronous write per core, one-cycle read latency,
    // optional corruption of address 2 on read-back.
    always @(posedge sys_clk) begin
        if (w_enable[0]) mem[0][w_adrs] <= w_instruction;
        if (w_enable[1]) mem[1][w_adrs] <= w_instruction;
        rd_data <= (corrupt && rd_adrs == 11'd2) ? 32'h1 : mem[rd_core][rd_adrs];
    end

    // Write and done monitor, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (w_enable != 2'b00) begin
            q_en.push_back(w_enable);
            q_adrs.push_back(w_adrs);
            q_data.push_back(w_instruction);
            wr_count++;
        end
        if (done) done_seen++;
    end

    task automatic clear_log();
        q_en.delete();
        q_adrs.delete();
        q_data.delete();
        done_seen = 0;
        wr_count  = 0;
    endtask

    // Pulse start for one cycle; returns at the negedge after acceptance.
    task automatic do_start(input logic [10:0] b, input logic [1:0] m);
        @(negedge sys_clk);
        start = 1'b1; base_adrs = b; core_mask = m;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    // Present one beat for one cycle; called and returns at a negedge.
    task automatic beat(input logic [31:0] d, input logic l);
        s_valid = 1'b1; s_data = d; s_last = l;
        @(negedge sys_clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    // Called at the negedge right after the last beat (cycle 1 after it);
    // returns the cycle number in which cpu_en is first seen high.
    task automatic wait_cpu(output int lat);
        lat = 1;
        while (cpu_en !== 1'b1 && lat < 100) begin
            @(negedge sys_clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        @(negedge sys_clk);
        n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL reset_cpu_en: got %b want 0", cpu_en); end
        n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
        n_cmp++; if (w_enable !== 2'b00) begin n_err++; $display("FAIL reset_w_enable: got %b want 00", w_enable); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (err !== 2'b00) begin n_err++; $display("FAIL reset_err: got %b want 00", err); end
        n_cmp++; if (word_count !== 12'd0) begin n_err++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
        n_cmp++; if (w_adrs !== 11'd0) begin n_err++; $display("FAIL reset_w_adrs: got %h want 0", w_adrs); end
        n_cmp++; if (w_instruction !== 32'd0) begin n_err++; $display("FAIL reset_w_instr: got %h want 0", w_instruction); end
        n_cmp++; if (rd_adrs !== 11'd0) begin n_err++; $display("FAIL reset_rd_adrs: got %h want 0", rd_adrs); end
        n_cmp++; if (rd_core !== 1'b0) begin n_err++; $display("FAIL reset_rd_core: got %b want 0", rd_core); end
    endtask

    task automatic test_basic_load();
        int lat;
        mem[1][0] = 32'h5a5a5a5a; mem[1][1] = 32'h5a5a5a5a;
        mem[1][2] = 32'h5a5a5a5a; mem[1][3] = 32'h5a5a5a5a;
        do_start(11'd0, 2'b01);
        clear_log();
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL basic_s_ready_rise: got %b want 1", s_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy); end
        for (int i = 0; i < 4; i++) beat(d4[i], i == 3);
        n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL basic_s_ready_fall: got %b want 0", s_ready); end
        n_cmp++; if (word_count !== 12'd4) begin n_err++; $display("FAIL basic_word_count: got %0d want 4", word_count); end
        wait_cpu(lat);
        n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL basic_latency: got %0d want 8", lat); end
        repeat (3) @(negedge sys_clk);
        n_cmp++; if (q_en.size() !== 4) begin n_err++; $display("FAIL basic_write_count: got %0d want 4", q_en.size()); end
        for (int i = 0; i < 4 && i < q_en.size(); i++) begin
            n_cmp++; if (q_en[i] !== 2'b01) begin n_err++; $display("FAIL basic_wen[%0d]: got %b want 01", i, q_en[i]); end
            n_cmp++; if (q_adrs[i] !== 11'(i)) begin n_err++; $display("FAIL basic_wadrs[%0d]: got %h want %h", i, q_adrs[i], i); end
            n_cmp++; if (q_data[i] !== d4[i]) begin n_err++; $display("FAIL basic_wdata[%0d]: got %h want %h", i, q_data[i], d4[i]); end
        end
        n_cmp++; if (mem[1][2] !== 32'h5a5a5a5a) begin n_err++; $display("FAIL basic_core1_untouched: got %h want 5a5a5a5a", mem[1][2]); end
        n_cmp++; if (done_seen !== 1) begin n_err++; $display("FAIL basic_done_pulses: got %0d want 1", done_seen); end
        n_cmp++; if (err !== 2'b00) begin n_err++; $display("FAIL basic_err: got %b want 00", err); end
        n_cmp++; if (cpu_en !== 1'b1) begin n_err++; $display("FAIL basic_cpu_en_hold: got %b want 1", cpu_en); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_checksum_error();
        int t;
        corrupt = 1'b1;
        do_start(11'd0, 2'b01);
        clear_log();
        for (int i = 0; i < 4; i++) beat(d4[i], i == 3);
        t = 0;
        while (err === 2'b00 && t < 100) begin @(negedge sys_clk); t++; end
        repeat (3) @(negedge sys_clk);
        n_cmp++; if (err !== 2'b01) begin n_err++; $display("FAIL cksum_err: got %b want 01", err); end
        n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL cksum_cpu_en: got %b want 0", cpu_en); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL cksum_busy: got %b want 0", busy); end
        n_cmp++; if (done_seen !== 0) begin n_err++; $display("FAIL cksum_done: got %0d want 0", done_seen); end
        // A start with an empty mask must be ignored, leaving ERROR intact.
        do_start(11'd0, 2'b00);
        @(negedge sys_clk);
        n_cmp++; if (err !== 2'b01) begin n_err++; $display("FAIL cksum_err_held: got %b want 01", err); end
        n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL cksum_zero_mask_ignored: got %b want 0", s_ready); end
        corrupt = 1'b0;
    endtask

    task automatic test_wrap();
        int lat;
        logic [10:0] exp_a [4];
        exp_a = '{11'h7fe, 11'h7ff, 11'h000, 11'h001};
        do_start(11'h7fe, 2'b11);
        clear_log();
        n_cmp++; if (err !== 2'b00) begin n_err++; $display("FAIL wrap_err_cleared: got %b want 00", err); end
        for (int i = 0; i < 4; i++) beat(32'hc0de0000 + 32'(i), i == 3);
        // Cycle 1 is DRAIN; verify addresses appear in cycles 2..5.
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            n_cmp++; if (rd_adrs !== exp_a[i]) begin n_err++; $display("FAIL wrap_rd_adrs[%0d]: got %h want %h", i, rd_adrs, exp_a[i]); end
            n_cmp++; if (rd_core !== 1'b0) begin n_err++; $display("FAIL wrap_rd_core[%0d]: got %b want 0", i, rd_core); end
        end
        wait_cpu(lat);
        n_cmp++; if (q_en.size() !== 4) begin n_err++; $display("FAIL wrap_write_count: got %0d want 4", q_en.size()); end
        for (int i = 0; i < 4 && i < q_en.size(); i++) begin
            n_cmp++; if (q_en[i] !== 2'b11) begin n_err++; $display("FAIL wrap_wen[%0d]: got %b want 11", i, q_en[i]); end
            n_cmp++; if (q_adrs[i] !== exp_a[i]) begin n_err++; $display("FAIL wrap_wadrs[%0d]: got %h want %h", i, q_adrs[i], exp_a[i]); end
        end
        n_cmp++; if (cpu_en !== 1'b1 || err !== 2'b00) begin n_err++; $display("FAIL wrap_run: got cpu_en=%b err=%b want 1/00", cpu_en, err); end
    endtask

    task automatic test_toggle_valid();
        int lat;
        do_start(11'h010, 2'b10);
        clear_log();
        for (int i = 0; i < 4; i++) begin
            beat(32'h100 + 32'(i), i == 3);
            n_cmp++; if (w_enable !== 2'b10) begin n_err++; $display("FAIL toggle_wen_on[%0d]: got %b want 10", i, w_enable); end
            n_cmp++; if (w_adrs !== 11'h010 + 11'(i)) begin n_err++; $display("FAIL toggle_wadrs[%0d]: got %h want %h", i, w_adrs, 11'h010 + 11'(i)); end
            if (i < 3) begin
                @(negedge sys_clk);
                n_cmp++; if (w_enable !== 2'b00) begin n_err++; $display("FAIL toggle_wen_off[%0d]: got %b want 00", i, w_enable); end
            end
        end
        @(negedge sys_clk);
        n_cmp++; if (rd_core !== 1'b1) begin n_err++; $display("FAIL toggle_rd_core: got %b want 1", rd_core); end
        n_cmp++; if (rd_adrs !== 11'h010) begin n_err++; $display("FAIL toggle_rd_adrs: got %h want 010", rd_adrs); end
        wait_cpu(lat);
        n_cmp++; if (lat !== 7) begin n_err++; $display("FAIL toggle_latency: got %0d want 7", lat); end
        n_cmp++; if (wr_count !== 4) begin n_err++; $display("FAIL toggle_write_count: got %0d want 4", wr_count); end
        n_cmp++; if (err !== 2'b00) begin n_err++; $display("FAIL toggle_err: got %b want 00", err); end
    endtask

    task automatic test_reset_mid_load();
        int lat;
        do_start(11'h020, 2'b01);
        beat(32'haaaa0001, 1'b0);
        beat(32'haaaa0002, 1'b0);
        resetn = 1'b0;
        #1;
        n_cmp++; if (w_enable !== 2'b00) begin n_err++; $display("FAIL rstmid_w_enable: got %b want 00", w_enable); end
        n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_s_ready: got %b want 0", s_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (word_count !== 12'd0) begin n_err++; $display("FAIL rstmid_word_count: got %0d want 0", word_count); end
        n_cmp++; if (w_adrs !== 11'd0 || w_instruction !== 32'd0) begin n_err++; $display("FAIL rstmid_wbus: got %h/%h want 0/0", w_adrs, w_instruction); end
        @(negedge sys_clk);
        resetn = 1'b1;
        do_start(11'h040, 2'b01);
        clear_log();
        for (int i = 0; i < 3; i++) beat(32'hbbbb0000 + 32'(i), i == 2);
        n_cmp++; if (word_count !== 12'd3) begin n_err++; $display("FAIL rstmid_reload_count: got %0d want 3", word_count); end
        wait_cpu(lat);
        n_cmp++; if (q_adrs.size() !== 3) begin n_err++; $display("FAIL rstmid_reload_writes: got %0d want 3", q_adrs.size()); end
        for (int i = 0; i < 3 && i < q_adrs.size(); i++) begin
            n_cmp++; if (q_adrs[i] !== 11'h040 + 11'(i)) begin n_err++; $display("FAIL rstmid_wadrs[%0d]: got %h want %h", i, q_adrs[i], 11'h040 + 11'(i)); end
        end
        n_cmp++; if (cpu_en !== 1'b1 || err !== 2'b00) begin n_err++; $display("FAIL rstmid_run: got cpu_en=%b err=%b want 1/00", cpu_en, err); end
    endtask

    task automatic test_overflow();
        do_start(11'd0, 2'b01);
        clear_log();
        for (int i = 0; i < 2048; i++) beat(32'(i), 1'b0);
        n_cmp++; if (word_count !== 12'd2048) begin n_err++; $display("FAIL ovf_full_count: got %0d want 2048", word_count); end
        n_cmp++; if (err !== 2'b00 || s_ready !== 1'b1) begin n_err++; $display("FAIL ovf_before: got err=%b s_ready=%b want 00/1", err, s_ready); end
        beat(32'hdeadbeef, 1'b0);
        n_cmp++; if (w_enable !== 2'b00) begin n_err++; $display("FAIL ovf_no_write: got %b want 00", w_enable); end
        n_cmp++; if (err !== 2'b10) begin n_err++; $display("FAIL ovf_err: got %b want 10", err); end
        n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL ovf_cpu_en: got %b want 0", cpu_en); end
        n_cmp++; if (s_ready !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL ovf_idle_flags: got s_ready=%b busy=%b want 0/0", s_ready, busy); end
        @(negedge sys_clk);
        n_cmp++; if (wr_count !== 2048) begin n_err++; $display("FAIL ovf_write_count: got %0d want 2048", wr_count); end
        n_cmp++; if (mem[0][11'h7ff] !== 32'd2047) begin n_err++; $display("FAIL ovf_last_word: got %h want %h", mem[0][11'h7ff], 32'd2047); end
        n_cmp++; if (word_count !== 12'd2048) begin n_err++; $display("FAIL ovf_count_hold: got %0d want 2048", word_count); end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; base_adrs = '0; core_mask = '0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        repeat (3) @(negedge sys_clk);
        resetn = 1'b1;
        test_reset();
        test_basic_load();
        test_checksum_error();
        test_wrap();
        test_toggle_valid();
        test_reset_mid_load();
        test_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
